// File: rtl/tl_burst_fragmenter.sv
// Splits TL-UH Get/Put bursts (8-64 B) into single-beat 4 B TL-UL accesses and merges the replies into one burst response.
// Latency: downstream A is one registered stage (1 cycle); the upstream D path is combinational from downstream D.
// Backpressure: the single A slot loads only when empty or draining; the D path passes ready through, except mid-Put acks, which are absorbed.
module tl_burst_fragmenter #(
  parameter int TL_RS    = 4,
  parameter int TL_AW    = 16,
  parameter int MAX_SIZE = 6
) (
  input  logic             frag_clock_i,
  input  logic             frag_reset_i,
  input  logic [2:0]       up_a_opcode,
  input  logic [2:0]       up_a_param,
  input  logic [3:0]       up_a_size,
  input  logic [TL_RS-1:0] up_a_source,
  input  logic [TL_AW-1:0] up_a_address,
  input  logic [3:0]       up_a_mask,
  input  logic [31:0]      up_a_data,
  input  logic             up_a_corrupt,
  input  logic             up_a_valid,
  output logic             up_a_ready,
  output logic [2:0]       up_d_opcode,
  output logic [1:0]       up_d_param,
  output logic [3:0]       up_d_size,
  output logic [TL_RS-1:0] up_d_source,
  output logic             up_d_denied,
  output logic [31:0]      up_d_data,
  output logic             up_d_corrupt,
  output logic             up_d_valid,
  input  logic             up_d_ready,
  output logic [2:0]       dn_a_opcode,
  output logic [2:0]       dn_a_param,
  output logic [3:0]       dn_a_size,
  output logic [TL_RS-1:0] dn_a_source,
  output logic [TL_AW-1:0] dn_a_address,
  output logic [3:0]       dn_a_mask,
  output logic [31:0]      dn_a_data,
  output logic             dn_a_corrupt,
  output logic             dn_a_valid,
  input  logic             dn_a_ready,
  input  logic [2:0]       dn_d_opcode,
  input  logic [1:0]       dn_d_param,
  input  logic [3:0]       dn_d_size,
  input  logic [TL_RS-1:0] dn_d_source,
  input  logic             dn_d_denied,
  input  logic [31:0]      dn_d_data,
  input  logic             dn_d_corrupt,
  input  logic             dn_d_valid,
  output logic             dn_d_ready,
  output logic             err_o
);

  localparam logic [2:0] OP_PUT_FULL = 3'd0;
  localparam logic [2:0] OP_PUT_PART = 3'd1;
  localparam logic [2:0] OP_GET      = 3'd4;
  localparam logic [2:0] D_ACK       = 3'd0;

  typedef enum logic [1:0] {IDLE, PASS, GET_ISSUE, PUT_ISSUE} state_t;

  state_t             state;
  logic [3:0]         lat_size;
  logic [TL_RS-1:0]   lat_source;
  logic [TL_AW-1:0]   lat_base;
  logic [3:0]         last_idx;    // N-1; N itself (16) does not fit in 4 bits
  logic [3:0]         issue_cnt;   // index of the next beat to issue
  logic               issue_done;
  logic [3:0]         rsp_cnt;
  logic               deny_acc;

  logic               slot_free;
  logic               is_small;
  logic               size_legal;
  logic               is_get;
  logic               is_put;
  logic [TL_AW-1:0]   size_mask;
  logic [TL_AW-1:0]   up_base;
  logic [15:0]        beats_raw;
  logic [3:0]         up_last_idx;
  logic [TL_AW-1:0]   beat_addr;
  logic               last_issue;

  // Request decode and burst address arithmetic.
  always_comb begin
    slot_free   = !dn_a_valid || dn_a_ready;
    is_small    = up_a_size <= 4'd2;
    size_legal  = up_a_size <= 4'(MAX_SIZE);
    is_get      = up_a_opcode == OP_GET;
    is_put      = (up_a_opcode == OP_PUT_FULL) || (up_a_opcode == OP_PUT_PART);
    size_mask   = (TL_AW'(1) << up_a_size) - TL_AW'(1);
    up_base     = up_a_address & ~size_mask;
    beats_raw   = 16'h1 << (up_a_size - 4'd2);
    up_last_idx = 4'(beats_raw - 16'd1);
    beat_addr   = lat_base + TL_AW'({issue_cnt, 2'b00});
    last_issue  = issue_cnt == last_idx;
  end

  // Handshake steering and upstream D reassembly; no state, no added latency.
  always_comb begin
    up_a_ready   = 1'b0;
    dn_d_ready   = 1'b0;
    up_d_valid   = 1'b0;
    up_d_opcode  = dn_d_opcode;
    up_d_param   = dn_d_param;
    up_d_size    = dn_d_size;
    up_d_source  = dn_d_source;
    up_d_denied  = dn_d_denied;
    up_d_data    = dn_d_data;
    up_d_corrupt = dn_d_corrupt;
    case (state)
      IDLE: up_a_ready = slot_free;
      PASS: begin
        up_d_valid = dn_d_valid;
        dn_d_ready = up_d_ready;
      end
      GET_ISSUE: begin
        up_d_valid = dn_d_valid;
        up_d_size  = lat_size;
        dn_d_ready = up_d_ready;
      end
      PUT_ISSUE: begin
        up_a_ready = slot_free && !issue_done;
        if (rsp_cnt == last_idx) begin
          up_d_valid  = dn_d_valid;
          dn_d_ready  = up_d_ready;
          up_d_opcode = D_ACK;
          up_d_param  = 2'd0;
          up_d_size   = lat_size;
          up_d_source = lat_source;
          up_d_denied = deny_acc || dn_d_denied;
        end else begin
          dn_d_ready = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Control FSM plus the registered downstream A slot.
  always_ff @(posedge frag_clock_i) begin
    if (frag_reset_i) begin
      state      <= IDLE;
      dn_a_valid <= 1'b0;
      err_o      <= 1'b0;
      issue_cnt  <= 4'd0;
      issue_done <= 1'b0;
      rsp_cnt    <= 4'd0;
      last_idx   <= 4'd0;
      deny_acc   <= 1'b0;
    end else begin
      err_o <= 1'b0;
      // Slot drains on acceptance; any load below overrides this.
      if (dn_a_ready) dn_a_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (up_a_valid && slot_free) begin
            lat_size   <= up_a_size;
            lat_source <= up_a_source;
            lat_base   <= up_base;
            last_idx   <= up_last_idx;
            issue_cnt  <= 4'd1;
            issue_done <= 1'b0;
            rsp_cnt    <= 4'd0;
            deny_acc   <= 1'b0;
            if (is_small) begin
              dn_a_valid   <= 1'b1;
              dn_a_opcode  <= up_a_opcode;
              dn_a_param   <= up_a_param;
              dn_a_size    <= up_a_size;
              dn_a_source  <= up_a_source;
              dn_a_address <= up_a_address;
              dn_a_mask    <= up_a_mask;
              dn_a_data    <= up_a_data;
              dn_a_corrupt <= up_a_corrupt;
              state        <= PASS;
            end else if (size_legal && (is_get || is_put)) begin
              dn_a_valid   <= 1'b1;
              dn_a_opcode  <= up_a_opcode;
              dn_a_param   <= is_get ? 3'd0 : up_a_param;
              dn_a_size    <= 4'd2;
              dn_a_source  <= up_a_source;
              dn_a_address <= up_base;
              dn_a_mask    <= is_get ? 4'hF : up_a_mask;
              dn_a_data    <= is_get ? 32'd0 : up_a_data;
              dn_a_corrupt <= is_get ? 1'b0 : up_a_corrupt;
              state        <= is_get ? GET_ISSUE : PUT_ISSUE;
            end else begin
              err_o <= 1'b1;
            end
          end
        end
        PASS: begin
          if (dn_d_valid && up_d_ready) state <= IDLE;
        end
        GET_ISSUE: begin
          if (slot_free && !issue_done) begin
            dn_a_valid   <= 1'b1;
            dn_a_opcode  <= OP_GET;
            dn_a_param   <= 3'd0;
            dn_a_size    <= 4'd2;
            dn_a_source  <= lat_source;
            dn_a_address <= beat_addr;
            dn_a_mask    <= 4'hF;
            dn_a_data    <= 32'd0;
            dn_a_corrupt <= 1'b0;
            if (last_issue) issue_done <= 1'b1;
            else            issue_cnt  <= issue_cnt + 4'd1;
          end
          if (dn_d_valid && up_d_ready) begin
            if (rsp_cnt == last_idx) state   <= IDLE;
            else                     rsp_cnt <= rsp_cnt + 4'd1;
          end
        end
        PUT_ISSUE: begin
          if (up_a_valid && slot_free && !issue_done) begin
            dn_a_valid   <= 1'b1;
            dn_a_opcode  <= up_a_opcode;
            dn_a_param   <= up_a_param;
            dn_a_size    <= 4'd2;
            dn_a_source  <= lat_source;
            dn_a_address <= beat_addr;
            dn_a_mask    <= up_a_mask;
            dn_a_data    <= up_a_data;
            dn_a_corrupt <= up_a_corrupt;
            if (last_issue) issue_done <= 1'b1;
            else            issue_cnt  <= issue_cnt + 4'd1;
          end
          if (dn_d_valid && dn_d_ready) begin
            if (rsp_cnt == last_idx) begin
              state <= IDLE;
            end else begin
              rsp_cnt  <= rsp_cnt + 4'd1;
              deny_acc <= deny_acc || dn_d_denied;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/tl_burst_fragmenter.md
Name: tl_burst_fragmenter

Overview:
- Sits directly upstream of the TileLink SRAM slave.
- Accepts TL-UH requests, including multi-beat Get and Put bursts of 8–64 bytes, and issues them downstream as a sequence of single-beat 4-byte TL-UL accesses.
- Reassembles downstream responses into one legal upstream burst response.
- Single-beat and atomic requests (size<=2) pass through unchanged.

Parameters:
- TL_RS, 4, source ID width.
- TL_AW, 16, address width.
- MAX_SIZE, 6, largest supported log2 transfer size (64 bytes, 16 beats).

Ports:
- frag_clock_i  in  1  clock
- frag_reset_i  in  1  synchronous active-high reset
- up_a_opcode/param/size/source/address/mask/data/corrupt  in  3/3/4/TL_RS/TL_AW/4/32/1  upstream A channel
- up_a_valid  in  1;  up_a_ready  out  1
- up_d_opcode/param/size/source/denied/data/corrupt  out  3/2/4/TL_RS/1/32/1  upstream D channel
- up_d_valid  out  1;  up_d_ready  in  1
- dn_a_opcode/param/size/source/address/mask/data/corrupt  out  3/3/4/TL_RS/TL_AW/4/32/1  downstream A channel (registered)
- dn_a_valid  out  1;  dn_a_ready  in  1
- dn_d_opcode/param/size/source/denied/data/corrupt  in  3/2/4/TL_RS/1/32/1  downstream D channel
- dn_d_valid  in  1;  dn_d_ready  out  1
- err_o  out  1  one-cycle pulse on an illegal request

Behaviour:
- Reset: dn_a_valid=0, up_d_valid=0, err_o=0, state=IDLE, counters=0. Data fields are don't-care.
- Reset mid-burst aborts the transaction; no further beats are issued.
- One upstream transaction is in flight at a time. No new A is accepted until its final upstream D beat handshakes.
- Downstream A slot is a 1-entry register. It loads when (!dn_a_valid | dn_a_ready). It holds all fields stable while dn_a_valid & !dn_a_ready.
- N = 2^(size-2) beats for size>=3. Beat counters are 4 bits wide.
- base = up_a_address with low size bits forced to 0. Beat i address = base + 4*i.
- States:
  - IDLE:
    - On up_a_valid & slot free, latch opcode/size/source/base.
    - size<=2, any opcode: forward beat verbatim, up_a_ready=1 → PASS.
    - Get with 3<=size<=MAX_SIZE: up_a_ready=1, issue beat 0 → GET_ISSUE.
    - PutFull/PutPartial with 3<=size<=MAX_SIZE: forward beat 0 → PUT_ISSUE.
    - Otherwise (atomic with size>2, or size>MAX_SIZE): up_a_ready=1, err_o=1, nothing issued, stay IDLE.
  - PASS:
    - dn_d forwards to up_d unchanged; dn_d_ready=up_d_ready.
    - On the handshake → IDLE.
  - GET_ISSUE:
    - Issue Gets of size 2, mask 4'hF, source=latched, one per free slot cycle, until issue_cnt=N.
    - Responses are concurrent: up_d = dn_d with size replaced by latched size; dn_d_ready=up_d_ready.
    - rsp_cnt increments per handshake. When rsp_cnt reaches N-1 and that beat handshakes → IDLE.
  - PUT_ISSUE:
    - up_a_ready = slot free. Each accepted beat goes downstream with size 2, beat address, that beat's mask/data, opcode as received.
    - Downstream AccessAcks 0..N-2 are consumed internally: dn_d_ready=1, not forwarded. A denied flag is OR-accumulated across them.
    - Ack N-1 is forwarded as AccessAck with size=latched size and denied=accumulated OR this beat's denied. dn_d_ready=up_d_ready for this ack.
    - → IDLE on that handshake.
- Downstream responds in order. The source is not used for matching.
- An upstream beat with a mismatched source/size mid-Put is not checked.
- up_d path is combinational from dn_d (no added latency). Downstream A adds exactly 1 cycle of latency.

Test Plan:
- Get size=2 addr 0x0010 → one dn Get size 2 addr 0x0010. dn AccessAckData 0xDEADBEEF returned upstream size 2, same source.
- Get size=4 addr 0x0043 source 3 → dn Gets at 0x0040/44/48/4C. Four up_d beats opcode 1 size 4 source 3, data in order.
- PutFull size=5 addr 0x0100, dn_a_ready low every other cycle → 8 dn Puts at 0x0100..0x011C with matching mask/data. Exactly one up_d AccessAck size 5 after the 8th dn ack. dn_a fields stable while stalled.
- Same Put with dn ack beat 2 denied=1 → final up AccessAck denied=1.
- ArithmeticData size=2 addr 0x0020 → forwarded verbatim. Response passed through unchanged.
- Get size=8 or LogicalData size=3 → err_o pulses once, up_a_ready=1, no dn_a_valid. frag_reset_i asserted mid Get size=6 after 5 beats → dn_a_valid=0 and up_d_valid=0 next cycle, IDLE.
